// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone initiator: one command in, one bus cycle,
// one response out, with a cycle timeout for slaves that never ack.
module wb_initiator #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_we,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] wb_addr,
  output logic [31:0]   wb_wdata,
  output logic          wb_we,
  output logic          wb_cyc,
  input  logic [31:0]   wb_rdata,
  input  logic          wb_ack,
  output logic          busy
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          rv_q, rv_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          tmo;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    rv_d    = rv_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo     = (TIMEOUT != 0) &&
              (cnt_q == CW'(TIMEOUT - 1));
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          we_d    = cmd_we;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        // ack takes priority over a simultaneous timeout
        if (wb_ack) begin
          cyc_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : wb_rdata;
          err_d   = 1'b0;
          rv_d    = 1'b1;
          state_d = RESP;
        end else if (tmo) begin
          cyc_d   = 1'b0;
          rdata_d = 32'h0;
          err_d   = 1'b1;
          rv_d    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wb_addr   = addr_q;
  assign wb_wdata  = wdata_q;
  assign wb_we     = we_q;
  assign wb_cyc    = cyc_q;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: register-slave model, response scoreboard,
// timing checks for accept/ack/timeout/backpressure/reset.
module tb_wb_initiator;

  localparam int AW = 16;
  localparam int TO = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_we = 1'b0;
  logic [31:0]   cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_wdata;
  logic          wb_we;
  logic          wb_cyc;
  logic [31:0]   wb_rdata;
  logic          wb_ack;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int cyc_hi = 0;
  int acks = 0;
  int rsp_cnt = 0;
  int rsp_cyc = 0;
  logic pending = 1'b0;
  exp_t q[$];

  logic [AW-1:0] cur_addr = '0;
  logic          cur_we = 1'b0;
  logic [31:0]   cur_wdata = '0;

  // slave: 0 = registered 1-cycle ack, 1 = never acks, 2 = ack on 8th cyc cycle
  int   mode = 0;
  logic ack_q = 1'b0;
  logic stray = 1'b0;
  int   seen = 0;

  always #5 clk = ~clk;

  wb_initiator #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_we(cmd_we), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_rdata(wb_rdata), .wb_ack(wb_ack),
    .busy(busy)
  );

  function automatic logic [31:0] f(input logic [AW-1:0] a);
    return {16'h0, a} ^ 32'h0000_0A58;
  endfunction

  always @(posedge clk) begin
    cyc_n   <= cyc_n + 1;
    pending <= rsp_valid & ~rsp_ready;
    seen    <= wb_cyc ? seen + 1 : 0;
    if (mode == 0)      ack_q <= wb_cyc & ~ack_q;
    else if (mode == 2) ack_q <= wb_cyc && (seen == TO - 2);
    else                ack_q <= 1'b0;
  end

  assign wb_ack   = ack_q | stray;
  assign wb_rdata = wb_ack ? f(wb_addr) : 32'h0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack_q) acks++;
      if (wb_cyc) begin
        cyc_hi++;
        checks++;
        if (wb_addr !== cur_addr || wb_we !== cur_we ||
            wb_wdata !== cur_wdata) begin
          failures++;
          $display("FAIL bus_hold addr=%h we=%b wdata=%h required %h %b %h",
                   wb_addr, wb_we, wb_wdata, cur_addr, cur_we, cur_wdata);
        end
      end
      if (rst_n && rsp_valid && !pending) begin
        rsp_cnt++;
        rsp_cyc = cyc_n;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp rdata=%h err=%b required none",
                   rsp_rdata, rsp_err);
        end else begin
          e = q.pop_front();
          if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            failures++;
            $display("FAIL rsp_data rdata=%h err=%b required %h %b",
                     rsp_rdata, rsp_err, e.rdata, e.err);
          end
        end
      end
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic we,
                      input logic [31:0] wd, input logic [31:0] er,
                      input logic ee, input bit push,
                      output int acc, output int waited);
    exp_t e;
    cmd_addr  = a;
    cmd_we    = we;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait cmd_ready=%b required 1", cmd_ready);
    end
    acc       = cyc_n + 1;
    cur_addr  = a;
    cur_we    = we;
    cur_wdata = wd;
    e.rdata   = er;
    e.err     = ee;
    if (push) q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_cnt < target) begin
      failures++;
      $display("FAIL rsp_wait count=%0d required %0d", rsp_cnt, target);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_cyc, wb_we, wb_addr, wb_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_bus cyc=%b we=%b addr=%h wdata=%h required 0",
               wb_cyc, wb_we, wb_addr, wb_wdata);
    end
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_rsp valid=%b rdata=%h err=%b required 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state ready=%b busy=%b required 1 0",
               cmd_ready, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write;
    int c0, k0, a, w;
    mode = 0;
    rsp_ready = 1'b1;
    c0 = cyc_hi;
    k0 = acks;
    send(16'h0, 1'b1, 32'h0000_0FFF, 32'h0, 1'b0, 1'b1, a, w);
    wait_rsp(rsp_cnt + 1);
    repeat (3) @(negedge clk);
    checks++;
    if (cyc_hi - c0 != 2) begin
      failures++;
      $display("FAIL wr_cyc_len cycles=%0d required 2", cyc_hi - c0);
    end
    checks++;
    if (acks - k0 != 1) begin
      failures++;
      $display("FAIL wr_ack_count acks=%0d required 1", acks - k0);
    end
    checks++;
    if (rsp_cyc != a + 2) begin
      failures++;
      $display("FAIL wr_latency edge=%0d required %0d", rsp_cyc, a + 2);
    end
    checks++;
    if (wb_we !== 1'b1 || wb_wdata !== 32'h0000_0FFF || wb_addr !== 16'h0) begin
      failures++;
      $display("FAIL wr_bus_keep we=%b wdata=%h addr=%h required 1 00000fff 0000",
               wb_we, wb_wdata, wb_addr);
    end
  endtask

  task automatic test_read;
    int c0, a, w;
    c0 = cyc_hi;
    send(16'h2, 1'b0, 32'h0, 32'h0000_0A5A, 1'b0, 1'b1, a, w);
    wait_rsp(rsp_cnt + 1);
    checks++;
    if (cyc_hi - c0 != 2 || wb_addr !== 16'h2) begin
      failures++;
      $display("FAIL rd_bus cycles=%0d addr=%h required 2 0002",
               cyc_hi - c0, wb_addr);
    end
  endtask

  task automatic test_timeout;
    int c0, a, w;
    mode = 1;
    c0 = cyc_hi;
    send(16'h1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, a, w);
    wait_rsp(rsp_cnt + 1);
    checks++;
    if (cyc_hi - c0 != TO || rsp_cyc != a + TO) begin
      failures++;
      $display("FAIL tmo_timing cycles=%0d edge=%0d required %0d %0d",
               cyc_hi - c0, rsp_cyc, TO, a + TO);
    end
    @(negedge clk);
    mode = 2;
    c0 = cyc_hi;
    send(16'h1, 1'b0, 32'h0, f(16'h1), 1'b0, 1'b1, a, w);
    wait_rsp(rsp_cnt + 1);
    checks++;
    if (cyc_hi - c0 != TO || rsp_cyc != a + TO) begin
      failures++;
      $display("FAIL tie_timing cycles=%0d edge=%0d required %0d %0d",
               cyc_hi - c0, rsp_cyc, TO, a + TO);
    end
    @(negedge clk);
    mode = 0;
  endtask

  task automatic test_backpressure;
    int c0, a, w, n;
    rsp_ready = 1'b0;
    c0 = cyc_hi;
    send(16'h3, 1'b0, 32'h0, f(16'h3), 1'b0, 1'b1, a, w);
    cmd_addr  = 16'h0;
    cmd_we    = 1'b1;
    cmd_wdata = 32'h55;
    cmd_valid = 1'b1;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== f(16'h3) ||
          cmd_ready !== 1'b0 || wb_cyc !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold valid=%b rdata=%h ready=%b cyc=%b required 1 %h 0 0",
                 rsp_valid, rsp_rdata, cmd_ready, wb_cyc, f(16'h3));
      end
    end
    checks++;
    if (cyc_hi - c0 != 2) begin
      failures++;
      $display("FAIL bp_extra_cyc cycles=%0d required 2", cyc_hi - c0);
    end
    rsp_ready = 1'b1;
    send(16'h0, 1'b1, 32'h55, 32'h0, 1'b0, 1'b1, a, w);
    checks++;
    if (w != 1) begin
      failures++;
      $display("FAIL bp_release waited=%0d required 1", w);
    end
    wait_rsp(rsp_cnt + 1);
  endtask

  task automatic test_back_to_back;
    int base, a0, a1, a2, w;
    rsp_ready = 1'b1;
    base = rsp_cnt;
    send(16'h1, 1'b1, 32'hAAAA_5555, 32'h0, 1'b0, 1'b1, a0, w);
    send(16'h2, 1'b0, 32'h0, f(16'h2), 1'b0, 1'b1, a1, w);
    send(16'h3, 1'b0, 32'h0, f(16'h3), 1'b0, 1'b1, a2, w);
    checks++;
    if (a1 - a0 != 4 || a2 - a1 != 4) begin
      failures++;
      $display("FAIL b2b_spacing gaps=%0d,%0d required 4,4", a1 - a0, a2 - a1);
    end
    wait_rsp(base + 3);
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL stray_ack valid=%b cyc=%b busy=%b required 0 0 0",
                 rsp_valid, wb_cyc, busy);
      end
    end
    checks++;
    if (rsp_cnt != base + 3) begin
      failures++;
      $display("FAIL b2b_count count=%0d required %0d", rsp_cnt, base + 3);
    end
  endtask

  task automatic test_reset_mid;
    int base, a, w;
    mode = 1;
    base = rsp_cnt;
    send(16'h1, 1'b1, 32'h77, 32'h0, 1'b0, 1'b0, a, w);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wb_cyc !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset cyc=%b busy=%b valid=%b required 0 0 0",
               wb_cyc, busy, rsp_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (rsp_cnt != base) begin
      failures++;
      $display("FAIL reset_drop count=%0d required %0d", rsp_cnt, base);
    end
    mode = 0;
    send(16'h1, 1'b1, 32'h77, 32'h0, 1'b0, 1'b1, a, w);
    wait_rsp(base + 1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_rsp left=%0d required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
